bit_serial_subtractor: RTL
==========================

Name: bit_serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor: diff = a - b - bin over WIDTH bits, one bit per clock.
- Built around a single combinational full-subtractor cell.
- Companion to the combinational full-adder datapath: the subtract direction, in sequential form.
- Used where area matters more than latency. A start/busy/done handshake lets a controller or bench sequence operand pairs.

Parameters:
- WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  request. Sampled only in IDLE; ignored in every other state.
- a  input  WIDTH  minuend. Captured on the accepted start cycle.
- b  input  WIDTH  subtrahend. Captured on the accepted start cycle.
- bin  input  1  borrow-in. Captured on the accepted start cycle.
- busy  output  1  high in SHIFT and DONE states
- done  output  1  one-cycle pulse; result valid
- diff  output  WIDTH  difference. Held stable from done until the next accepted start.
- bout  output  1  final borrow-out. Held with diff.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE
  - a_sr, b_sr, diff_sr, count all 0
  - borrow=0, busy=0, done=0, diff=0, bout=0
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1: a_sr<=a, b_sr<=b, borrow<=bin, count<=0, diff_sr<=0; go to SHIFT.
  - Otherwise stay in IDLE; diff and bout keep their last values.
- SHIFT, each cycle (x=a_sr[0], y=b_sr[0], br=borrow):
  - d = x^y^br
  - br_n = (~x&y) | (~(x^y)&br)
  - diff_sr <= {d, diff_sr[WIDTH-1:1]}
  - a_sr and b_sr shift right by 1, filling with 0
  - borrow <= br_n, count <= count+1
  - When count==WIDTH-1, go to DONE. This gives exactly WIDTH shift cycles.
- DONE:
  - done=1 for exactly one cycle; diff=diff_sr, bout=borrow.
  - Go to IDLE unconditionally.
- Latency: start accepted at edge N. done is high in the cycle after edge N+WIDTH, i.e. WIDTH+1 cycles after acceptance.
- Throughput: earliest next start is sampled in the cycle after done, giving one result per WIDTH+2 cycles.
- diff and bout are registered. They update only on entry to DONE, never mid-shift.
- Width and wrap-around:
  - Result is modulo 2^WIDTH.
  - bout=1 exactly when a < b+bin, comparing as unsigned values.
  - Arithmetic identity: {bout, diff} == (a - b - bin) mod 2^(WIDTH+1).
- count is $clog2(WIDTH)+1 bits wide, so it never wraps before terminal.
- Simultaneous events: start asserted while busy (SHIFT or DONE) is dropped. The block does not queue it, and operands in flight are untouched.
- Reset mid-operation: immediate abort. All outputs take their reset values, and no done pulse is issued for the aborted operation.
- Operand inputs are don't-care outside the accepted start cycle.

Decomposition:
- Shared package bit_serial_sub_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
  - default WIDTH constant
- One sub-module: full_subtractor, a pure combinational cell.
  - Inputs: x, y, bin. Outputs: d, bout.
  - Instantiated once in the SHIFT datapath.

Test Plan:
- WIDTH=8, a=5, b=3, bin=0 -> done 9 cycles after start, diff=8'h02, bout=0, busy high for those 9 cycles.
- a=3, b=5, bin=0 -> diff=8'hFE, bout=1 (borrow wrap-around).
- a=0, b=0, bin=1 -> diff=8'hFF, bout=1. Separately, a=8'hFF, b=8'hFF, bin=1 -> diff=8'hFF, bout=1.
- Start a=9, b=4, then pulse start with a=1, b=1 at cycle 3 of SHIFT -> second start ignored; single done with diff=8'h05, bout=0.
- Assert rst in cycle 4 of SHIFT -> busy, done, diff and bout go to 0 asynchronously, no done follows. A new start a=7, b=2 -> diff=8'h05.
- WIDTH=2 build: exhaustive sweep of all 32 (a,b,bin) combinations, checked against the {bout,diff} identity. Back-to-back starts issued on the cycle after each done.

Source files
------------

// File: rtl/bit_serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor slice.
package bit_serial_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the bit-serial subtractor.
interface bit_serial_subtractor_if #(
  parameter int unsigned WIDTH = bit_serial_sub_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, output a, output b, output bin,
                  input  busy,  input  done, input diff, input bout);

  modport slave  (input  start, input  a, input  b, input  bin,
                  output busy,  output done, output diff, output bout);
endinterface

// File: rtl/bit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_subtractor.sv
// LSB-first serial subtractor: one full-subtractor cell reused over WIDTH cycles.
module bit_serial_subtractor
  import bit_serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                    clk,
  input logic                    rst,
  bit_serial_subtractor_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  state_e           state_q,   state_d;
  logic [WIDTH-1:0] a_sr_q,    a_sr_d;
  logic [WIDTH-1:0] b_sr_q,    b_sr_d;
  logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
  logic [CW-1:0]    count_q,   count_d;
  logic             borrow_q,  borrow_d;
  logic             busy_q,    busy_d;
  logic             done_q,    done_d;
  logic [WIDTH-1:0] diff_q,    diff_d;
  logic             bout_q,    bout_d;

  logic fs_d;
  logic fs_bout;

  full_subtractor u_fs (
    .x    (a_sr_q[0]),
    .y    (b_sr_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      diff_sr_q <= '0;
      count_q   <= '0;
      borrow_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sr_q    <= a_sr_d;
      b_sr_q    <= b_sr_d;
      diff_sr_q <= diff_sr_d;
      count_q   <= count_d;
      borrow_q  <= borrow_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      diff_q    <= diff_d;
      bout_q    <= bout_d;
    end
  end

  // Next-state and datapath; results are published only on the final shift.
  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    diff_sr_d = diff_sr_q;
    count_d   = count_q;
    borrow_d  = borrow_q;
    done_d    = 1'b0;
    diff_d    = diff_q;
    bout_d    = bout_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_sr_d    = bus.a;
          b_sr_d    = bus.b;
          borrow_d  = bus.bin;
          count_d   = '0;
          diff_sr_d = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        diff_sr_d = {fs_d, diff_sr_q[WIDTH-1:1]};
        a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
        borrow_d  = fs_bout;
        count_d   = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          diff_d  = {fs_d, diff_sr_q[WIDTH-1:1]};
          bout_d  = fs_bout;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule
